mips_imem_responder: RTL

MIPS_IMEM_RESPONDER -- requirements
Module: mips_imem_responder

---
 rtl/mips_imem_responder.sv | 114 +++++++++++
 1 files changed

// File: rtl/mips_imem_responder.sv
// rtl/mips_imem_responder.sv - instruction memory fetch responder with fixed wait latency and load port
// Optional IMEM_ERR_CNT_EN adds a saturating faulting-response counter on err_cnt.
module mips_imem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_inst,
    output logic                  rsp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
`ifdef IMEM_ERR_CNT_EN
    input  logic [31:0]           ld_data,
    output logic [7:0]            err_cnt
`else
    input  logic [31:0]           ld_data
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];
    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [31:0]           addr_q;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_inst_q;
    logic                  rsp_err_q;

    logic                  accept;
    logic                  enter_resp;
    logic [31:0]           rd_addr;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  fault;

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

    // With no wait cycles the lookup happens on the accept edge, so use the live address there.
    assign rd_addr    = (state_q == S_IDLE) ? req_addr : addr_q;
    assign rd_idx     = rd_addr[DEPTH_LOG2+1:2];
    assign fault      = (rd_addr[1:0] != 2'b00) || ((rd_addr[31:2] >> DEPTH_LOG2) != 30'd0);
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q <= 4'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_inst_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= enter_resp;
            if (enter_resp) begin
                rsp_err_q  <= fault;
                rsp_inst_q <= fault ? 32'd0 : mem[rd_idx];
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_RESP;
                        cnt_q   <= 4'd0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Storage is never cleared; reset only suppresses a coincident load write.
    always_ff @(posedge clk) begin
        if (!reset && ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_inst  = rsp_inst_q;
    assign rsp_err   = rsp_err_q;

`ifdef IMEM_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else if (enter_resp && fault && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
